mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit, downstream of the EX/MEM pipeline register.
//  Runs a registered req/ack transaction to data memory for loads and stores, and generates byte enables.
//  Aligns and sign-extends load data, and holds the pipeline (stall_out) until the access completes.
//  Also resolves BEQ/BNE (PCSrc_out) from Branch/zero/funct3.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max WAIT cycles without dmem_ack before abort (>=2)
//  CNT_W           7   timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk              in   1   clock, rising edge
//  res              in   1   asynchronous, active-low reset
//  funct3_in        in   3   access size/sign, branch kind
//  zero_in          in   1   ALU zero flag
//  ALU_in           in   32  effective address
//  reg2_data_in     in   32  store data (rs2)
//  Branch_MEM_in    in   1   branch instruction
//  MemRead_MEM_in   in   1   load
//  MemWrite_MEM_in  in   1   store
//  dmem_ack         in   1   memory done (1-cycle pulse)
//  dmem_rdata       in   32  read word, valid with ack
//  dmem_req         out  1   request, held until ack/abort
//  dmem_we          out  1   1 = write
//  dmem_addr        out  32  word address {ALU_in[31:2],2'b00}
//  dmem_wdata       out  32  lane-replicated store data
//  dmem_be          out  4   byte enables
//  load_data_out    out  32  aligned/extended load result
//  stall_out        out  1   hold IF..EX/MEM write enables low
//  PCSrc_out        out  1   take branch
//  fault_out        out  1   1-cycle pulse: misaligned/illegal/timeout
// BEHAVIOUR
//  Reset: all registered outputs 0, state IDLE, counter 0; stall_out forced 0 while res low.
//  Reset mid-access drops dmem_req immediately (async).
//  acc = MemRead|MemWrite (both set -> illegal). bad = illegal funct3 or misaligned:
//   - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU are legal.
//   - stores: 000 SB, 001 SH, 010 SW are legal.
//   - half access with addr[0]=1, or word access with addr[1:0]!=0, is misaligned.
//  FSM IDLE/WAIT/DONE:
//   IDLE: acc&!bad -> register req=1, we, addr, wdata, be; go to WAIT.
//         acc&bad -> fault_out=1 for 1 cycle, load_data_out=0, no request, stay IDLE.
//   WAIT: counter++ each cycle. dmem_ack -> req=0, latch aligned load_data_out (loads only), go to DONE.
//         Ack in the first WAIT cycle is legal (min latency 3 cycles IDLE->WAIT->DONE).
//         counter==TIMEOUT_CYCLES-1 & !ack -> req=0, fault_out=1, load_data_out=0, go to DONE.
//   DONE: unconditionally go to IDLE; counter cleared.
//  stall_out = acc & !bad & (state!=DONE), combinational; low in DONE so EX/MEM advances on that edge.
//  Store lanes:
//   - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
//   - SH: be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}.
//   - SW: be=1111, wdata=rs2.
//  Loads: be=1111, we=0; select byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
//  dmem_* outputs stay stable while req=1; ALU_in changes in WAIT are ignored (registered copy used).
//  PCSrc_out = Branch & (f3==000 ? zero : f3==001 ? !zero : 0), combinational, independent of FSM.
//  load_data_out holds its value until the next completed load or fault.
// STRUCTURE
//  Package risc_pkg:
//   - F3_B/H/W/BU/HU and F3_BEQ/BNE constants.
//   - lsu_state_t {IDLE,WAIT,DONE}.
//  Sub-module lsu_align (combinational): funct3+addr+rs2/rdata -> be, wdata, load value, misaligned/illegal flags.
//  FSM, timeout counter and output registers stay in mem_stage_lsu.
// TESTING
//  1. SW x=0xDEADBEEF @0x100, ack after 2 WAIT cycles:
//     req=1, we=1, be=1111, addr=0x100; stall high 3 cycles then low.
//  2. LB @0x103, rdata=0x80FF_FF7F: load_data_out=0xFFFF_FF80. LBU same: 0x0000_0080.
//  3. SH rs2=0x1234 @0x0A: be=1100, wdata=0x1234_1234.
//     LH @0x0A with rdata=0x8001_0000: 0xFFFF_8001.
//  4. LW @0x102: fault_out pulse, dmem_req never asserted, stall_out=0.
//  5. LW with no ack: req drops and fault pulses after 64 WAIT cycles; FSM returns to IDLE.
//     res low during WAIT: req=0 in the same cycle.
//  6. Branch=1, f3=001, zero=0 -> PCSrc_out=1; f3=000, zero=0 -> 0.
//     Back-to-back SW then LW: each access completes with one DONE cycle between.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg: shared funct3 encodings and LSU state type for the MEM stage
package risc_pkg;
    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, store lane replication, load extraction and legality checks
module lsu_align
    import risc_pkg::*;
(
    input  logic [2:0]  i_f3,
    input  logic [1:0]  i_a,
    input  logic        i_store,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld,
    output logic        o_mis,
    output logic        o_ill
);
    logic        w_h;
    logic        w_w;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_ld_ok;
    assign w_h     = i_f3[1:0] == 2'b01;
    assign w_w     = i_f3[1:0] == 2'b10;
    assign w_byte  = i_a == 2'd3 ? i_rdata[31:24] : i_a == 2'd2 ? i_rdata[23:16] :
                     i_a == 2'd1 ? i_rdata[15:8] : i_rdata[7:0];
    assign w_half  = i_a[1] ? i_rdata[31:16] : i_rdata[15:0];
    assign w_ld_ok = i_f3 == F3_B || i_f3 == F3_H || i_f3 == F3_W || i_f3 == F3_BU || i_f3 == F3_HU;
    assign o_mis   = (w_h & i_a[0]) | (w_w & |i_a);
    assign o_ill   = i_store ? (i_f3[2] | &i_f3[1:0]) : !w_ld_ok;
    assign o_be    = !i_store ? 4'b1111 : w_w ? 4'b1111 :
                     w_h ? (i_a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << i_a;
    assign o_wdata = w_w ? i_rs2 : w_h ? {2{i_rs2[15:0]}} : {4{i_rs2[7:0]}};
    // f3[2] selects zero-extension (LBU/LHU)
    assign o_ld    = w_w ? i_rdata :
                     w_h ? {{16{!i_f3[2] & w_half[15]}}, w_half} :
                           {{24{!i_f3[2] & w_byte[7]}}, w_byte};
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with req/ack handshake, timeout and branch resolve
module mem_stage_lsu
    import risc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        res,
    input  logic [2:0]  funct3_in,
    input  logic        zero_in,
    input  logic [31:0] ALU_in,
    input  logic [31:0] reg2_data_in,
    input  logic        Branch_MEM_in,
    input  logic        MemRead_MEM_in,
    input  logic        MemWrite_MEM_in,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic [31:0] load_data_out,
    output logic        stall_out,
    output logic        PCSrc_out,
    output logic        fault_out
);
    lsu_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [1:0]       r_a;
    logic [2:0]       r_f3;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;
    logic [31:0]      r_ld;
    logic             r_fault;
    logic             w_idle;
    logic             w_acc;
    logic             w_bad;
    logic             w_mis;
    logic             w_ill;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_ld;
    assign w_idle = r_state == IDLE;
    assign w_acc  = MemRead_MEM_in | MemWrite_MEM_in;
    assign w_bad  = w_mis | w_ill | (MemRead_MEM_in & MemWrite_MEM_in);
    // In IDLE the live instruction is decoded; once issued, the registered copy drives alignment
    lsu_align u_align (
        .i_f3    (w_idle ? funct3_in : r_f3),
        .i_a     (w_idle ? ALU_in[1:0] : r_a),
        .i_store (w_idle ? MemWrite_MEM_in : r_we),
        .i_rs2   (reg2_data_in),
        .i_rdata (dmem_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_ld    (w_ld),
        .o_mis   (w_mis),
        .o_ill   (w_ill)
    );
    assign stall_out     = res & w_acc & !w_bad & (r_state != DONE);
    assign PCSrc_out     = Branch_MEM_in & (funct3_in == F3_BEQ ? zero_in : funct3_in == F3_BNE ? !zero_in : 1'b0);
    assign dmem_req      = r_req;
    assign dmem_we       = r_we;
    assign dmem_addr     = r_addr;
    assign dmem_wdata    = r_wdata;
    assign dmem_be       = r_be;
    assign load_data_out = r_ld;
    assign fault_out     = r_fault;
    // Access FSM: issue, wait for ack or timeout, then one DONE cycle to release the pipeline
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_a     <= '0;
            r_f3    <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_ld    <= '0;
            r_fault <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_acc && w_bad) begin
                        r_fault <= 1'b1;
                        r_ld    <= '0;
                    end else if (w_acc) begin
                        r_req   <= 1'b1;
                        r_we    <= MemWrite_MEM_in;
                        r_addr  <= {ALU_in[31:2], 2'b00};
                        r_a     <= ALU_in[1:0];
                        r_f3    <= funct3_in;
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                        r_cnt   <= '0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (dmem_ack) begin
                        r_req   <= 1'b0;
                        r_ld    <= r_we ? r_ld : w_ld;
                        r_state <= DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_req   <= 1'b0;
                        r_fault <= 1'b1;
                        r_ld    <= '0;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
